// File: rtl/playback_prefetch_buffer_if.sv
// ============================================================================
// Module  : playback_prefetch_buffer_if
// Purpose : RAM-wrapper read handshake bundle between the playback prefetch
//           buffer (master) and the DDR RAM wrapper (slave).
// Signals : rdy           - RAM wrapper ready to accept a request
//           read_request  - one-cycle read request (master -> slave)
//           ram_address   - word address of the current/next read
//           rd_data_pres  - read data valid (slave -> master)
//           ram_data      - read data
//           read_ack      - one-cycle read acknowledge (master -> slave)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface playback_prefetch_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 26
);
  logic              rdy;
  logic              read_request;
  logic              rd_data_pres;
  logic [DATA_W-1:0] ram_data;
  logic              read_ack;
  logic [ADDR_W-1:0] ram_address;

  modport master (
    input  rdy, rd_data_pres, ram_data,
    output read_request, read_ack, ram_address
  );

  modport slave (
    output rdy, rd_data_pres, ram_data,
    input  read_request, read_ack, ram_address
  );
endinterface

`default_nettype wire

// File: rtl/playback_prefetch_buffer.sv
// ============================================================================
// Module  : playback_prefetch_buffer
// Purpose : Reads playback samples ahead from RAM into a small FIFO and hands
//           one sample to the codec per (synchronised) sample request, so RAM
//           latency never stalls the DAC. Counts empty-FIFO pops (underruns).
// Ports   : systemCLK, pb_reset (async, active-high)
//           i_play, i_pause, i_restart, i_start_address, i_end_address
//           ram                 - RAM read handshake (interface, master side)
//           i_sample_req_async  - codec request strobe (audio_clk domain)
//           o_sample_out, o_fifo_level, o_underrun_count, o_done
// Options : LOOP_PLAYBACK_EN - when defined, playback wraps from end_address
//           back to start_address instead of stopping in END.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module playback_prefetch_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 26,
  parameter int DEPTH  = 8
) (
  input  wire logic                    systemCLK,
  input  wire logic                    pb_reset,
  input  wire logic                    i_play,
  input  wire logic                    i_pause,
  input  wire logic                    i_restart,
  input  wire logic [ADDR_W-1:0]       i_start_address,
  input  wire logic [ADDR_W-1:0]       i_end_address,
  playback_prefetch_buffer_if.master   ram,
  input  wire logic                    i_sample_req_async,
  output logic [DATA_W-1:0]            o_sample_out,
  output logic [$clog2(DEPTH):0]       o_fifo_level,
  output logic [7:0]                   o_underrun_count,
  output logic                         o_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_ACK  = 3'd3,
    S_END  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_read_request;
  logic              r_read_ack;
  logic              r_stale;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;

  logic              r_sync1, r_sync2, r_sync3, r_pop;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_sample;
  logic [7:0]        r_underrun;

  logic              w_run;
  logic              w_pop_ok;
  logic              w_underrun;
  logic              w_push;
  logic [ADDR_W:0]   w_addr_inc;
  logic              w_step_end;
  logic              w_can_req;
  state_t            w_restart_state;

  assign w_run      = i_play & ~i_pause;
  assign w_pop_ok   = r_pop & w_run & (r_level != '0);
  // Running dry after the last word has been fetched is normal end of play.
  assign w_underrun = r_pop & w_run & (r_level == '0) & (r_state != S_END);
  // Data of a read that was overtaken by restart is dropped on the floor.
  assign w_push     = (r_state == S_WAIT) & ram.rd_data_pres & ~r_stale & ~i_restart;
  // Extra carry bit catches the wrap at the top of the address space.
  assign w_addr_inc = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_step_end = w_addr_inc[ADDR_W] | (w_addr_inc[ADDR_W-1:0] > i_end_address);
  assign w_can_req  = w_run & ram.rdy & (r_level < FULL_LVL) & (r_addr <= i_end_address);

`ifdef LOOP_PLAYBACK_EN
  assign w_restart_state = S_IDLE;
`else
  assign w_restart_state = (i_start_address > i_end_address) ? S_END : S_IDLE;
`endif

  assign ram.read_request = r_read_request;
  assign ram.read_ack     = r_read_ack;
  assign ram.ram_address  = r_addr;
  assign o_sample_out     = r_sample;
  assign o_fifo_level     = r_level;
  assign o_underrun_count = r_underrun;
  assign o_done           = r_done;

  // Request synchroniser, edge detect and prefetch FSM.
  always_ff @(posedge systemCLK or posedge pb_reset) begin
    if (pb_reset) begin
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_sync3        <= 1'b0;
      r_pop          <= 1'b0;
      r_state        <= S_IDLE;
      r_read_request <= 1'b0;
      r_read_ack     <= 1'b0;
      r_stale        <= 1'b0;
      r_done         <= 1'b0;
      r_addr         <= '0;
    end else begin
      r_sync1        <= i_sample_req_async;
      r_sync2        <= r_sync1;
      r_sync3        <= r_sync2;
      r_pop          <= r_sync2 & ~r_sync3;
      r_read_request <= 1'b0;
      r_read_ack     <= 1'b0;
      r_done         <= (r_state == S_END) && (r_level == '0);

      case (r_state)
        S_IDLE: begin
          if (!i_restart && w_can_req) begin
            r_state        <= S_REQ;
            r_read_request <= 1'b1;
            r_stale        <= 1'b0;
          end
        end
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          if (ram.rd_data_pres) begin
            r_state    <= S_ACK;
            r_read_ack <= 1'b1;
          end
        end
        S_ACK: begin
          if (r_stale || i_restart) begin
            // Address was already reloaded by restart; do not advance it.
            r_state <= w_restart_state;
          end else if (w_step_end) begin
`ifdef LOOP_PLAYBACK_EN
            r_addr  <= i_start_address;
            r_state <= S_IDLE;
`else
            r_addr  <= w_addr_inc[ADDR_W-1:0];
            r_state <= S_END;
`endif
          end else begin
            r_addr  <= w_addr_inc[ADDR_W-1:0];
            r_state <= S_IDLE;
          end
        end
        S_END: r_state <= S_END;
        default: r_state <= S_IDLE;
      endcase

      if (i_restart) begin
        r_addr  <= i_start_address;
        r_done  <= 1'b0;
        // A read already on the bus must finish its handshake; mark it stale.
        r_stale <= (r_state == S_REQ) || (r_state == S_WAIT);
        if ((r_state == S_IDLE) || (r_state == S_END)) begin
          r_state <= w_restart_state;
        end
      end
    end
  end

  // FIFO pointers, occupancy, sample output and underrun counter.
  always_ff @(posedge systemCLK or posedge pb_reset) begin
    if (pb_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_sample   <= '0;
      r_underrun <= '0;
    end else if (i_restart) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_underrun <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (r_pop) begin
        r_sample <= w_pop_ok ? r_mem[r_rd_ptr] : '0;
      end
      case ({w_push, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_underrun && (r_underrun != 8'hFF)) begin
        r_underrun <= r_underrun + 8'd1;
      end
    end
  end

  // Sample storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge systemCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ram.ram_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_playback_prefetch_buffer.sv
// ============================================================================
// Module  : tb_playback_prefetch_buffer
// Purpose : Self-checking bench for playback_prefetch_buffer. A behavioural
//           RAM returns 0xA000 + address after a programmable latency.
//           Expected samples are queued when a playback range is started and
//           compared as the codec requests pop them.
// Options : LOOP_PLAYBACK_EN - adds the looping-address sequence.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_playback_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        play, pause, restart, sreq;
  logic [25:0] start_a, end_a;
  logic [15:0] sample_out;
  logic [3:0]  level;
  logic [7:0]  underrun;
  logic        done;

  playback_prefetch_buffer_if #(.DATA_W(16), .ADDR_W(26)) bus ();

  playback_prefetch_buffer dut (
    .systemCLK          (clk),
    .pb_reset           (rst),
    .i_play             (play),
    .i_pause            (pause),
    .i_restart          (restart),
    .i_start_address    (start_a),
    .i_end_address      (end_a),
    .ram                (bus.master),
    .i_sample_req_async (sreq),
    .o_sample_out       (sample_out),
    .o_fifo_level       (level),
    .o_underrun_count   (underrun),
    .o_done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model (updates on the falling edge) ----------------
  int          lat;
  int          rd_cnt;
  int          ack_cnt;
  int          ram_cnt;
  bit          ram_busy;
  logic [25:0] ram_addr_l;
  logic [25:0] obs_addr_q[$];

  initial begin
    rd_cnt   = 0;
    ack_cnt  = 0;
    ram_cnt  = 0;
    ram_busy = 1'b0;
    bus.rd_data_pres = 1'b0;
    bus.ram_data     = '0;
  end

  always @(negedge clk) begin
    bus.rd_data_pres = 1'b0;
    if (bus.read_ack) ack_cnt++;
    if (ram_busy) begin
      if (ram_cnt <= 1) begin
        bus.rd_data_pres = 1'b1;
        bus.ram_data     = 16'hA000 + ram_addr_l[15:0];
        ram_busy         = 1'b0;
      end else begin
        ram_cnt--;
      end
    end
    if (bus.read_request) begin
      rd_cnt++;
      obs_addr_q.push_back(bus.ram_address);
      ram_addr_l = bus.ram_address;
      ram_cnt    = lat;
      ram_busy   = 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  int total;
  int bad;
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_restart(input logic [25:0] s, input logic [25:0] e);
    start_a = s;
    end_a   = e;
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
  endtask

  // Holds the request high across several clocks, then lets the pop land.
  task automatic sample_req();
    sreq = 1'b1;
    cycles(3);
    sreq = 1'b0;
    cycles(4);
  endtask

  task automatic chk_addr(input string nm, input int ix, input logic [25:0] exp);
    if (ix < obs_addr_q.size()) chk(nm, 32'(obs_addr_q[ix]), 32'(exp));
    else                        chk({nm, "_missing"}, 32'(obs_addr_q.size()), 32'(ix + 1));
  endtask

  typedef struct {
    logic [25:0] s;
    logic [25:0] e;
    int          lat;
    int          n;
    int          lvl;
  } vec_t;

  vec_t        tbl[5];
  int          base_rd, base_ix, base_ack, u0, bn;
  bit          ok;
  logic [25:0] a;
  logic [15:0] es;

  initial begin
    total = 0;
    bad   = 0;
    // start, end, latency, reads expected, fifo level after prefetch
    tbl[0] = '{26'h0000100, 26'h0000103, 3, 4, 4};
    tbl[1] = '{26'h0000200, 26'h0000200, 1, 1, 1};
    tbl[2] = '{26'h0000305, 26'h0000300, 2, 0, 0};
    tbl[3] = '{26'h3FFFFFE, 26'h3FFFFFF, 2, 2, 2};
    tbl[4] = '{26'h0000500, 26'h0000506, 5, 7, 7};

    rst = 1'b1; play = 1'b0; pause = 1'b0; restart = 1'b0; sreq = 1'b0;
    start_a = '0; end_a = '0; lat = 3;
    bus.rdy = 1'b1;
    cycles(2);
    chk("rst_read_request", 32'(bus.read_request), 0);
    chk("rst_read_ack",     32'(bus.read_ack), 0);
    chk("rst_ram_address",  32'(bus.ram_address), 0);
    chk("rst_sample_out",   32'(sample_out), 0);
    chk("rst_fifo_level",   32'(level), 0);
    chk("rst_underrun",     32'(underrun), 0);
    chk("rst_done",         32'(done), 0);
    rst = 1'b0;
    cycles(2);

    // ---- table-driven playback ranges ----
    for (int v = 0; v < 5; v++) begin
      lat     = tbl[v].lat;
      base_rd = rd_cnt;
      base_ix = obs_addr_q.size();
      for (int i = 0; i < tbl[v].n; i++) begin
        a = tbl[v].s + 26'(i);
        exp_q.push_back(16'hA000 + a[15:0]);
      end
      pulse_restart(tbl[v].s, tbl[v].e);
      play = 1'b1;
      cycles(120);
      chk($sformatf("v%0d_reads", v), 32'(rd_cnt - base_rd), 32'(tbl[v].n));
      chk($sformatf("v%0d_level", v), 32'(level), 32'(tbl[v].lvl));
      for (int i = 0; i < tbl[v].n; i++)
        chk_addr($sformatf("v%0d_addr%0d", v, i), base_ix + i, tbl[v].s + 26'(i));
      for (int i = 0; i < tbl[v].n; i++) begin
        sample_req();
        es = exp_q.pop_front();
        chk($sformatf("v%0d_sample%0d", v, i), 32'(sample_out), 32'(es));
      end
      sample_req();
      cycles(2);
      chk($sformatf("v%0d_end_pop", v), 32'(sample_out), 0);
      chk($sformatf("v%0d_underrun", v), 32'(underrun), 0);
      chk($sformatf("v%0d_done", v), 32'(done), 1);
      chk($sformatf("v%0d_drained", v), 32'(level), 0);
    end

    // ---- full FIFO throttles prefetch; one pop frees exactly one read ----
    lat     = 3;
    base_rd = rd_cnt;
    exp_q.push_back(16'hB000);
    pulse_restart(26'h1000, 26'h1FFF);
    cycles(150);
    chk("full_reads", 32'(rd_cnt - base_rd), 8);
    chk("full_level", 32'(level), 8);
    chk("full_done",  32'(done), 0);
    cycles(50);
    chk("full_no_more_reads", 32'(rd_cnt - base_rd), 8);
    sample_req();
    es = exp_q.pop_front();
    chk("full_pop_sample", 32'(sample_out), 32'(es));
    cycles(30);
    chk("full_one_more_read", 32'(rd_cnt - base_rd), 9);
    chk("full_refilled", 32'(level), 8);

    // ---- slow RAM: pops on an empty FIFO count as underruns ----
    lat = 200;
    pulse_restart(26'h2000, 26'h2FFF);
    chk("slow_underrun_cleared", 32'(underrun), 0);
    for (int k = 0; k < 4; k++) begin
      sample_req();
      chk($sformatf("slow_sample%0d", k), 32'(sample_out), 0);
      chk($sformatf("slow_underrun%0d", k), 32'(underrun), 32'(k + 1));
      cycles(43);
    end

    // ---- restart while a read sits in WAIT ----
    bn = rd_cnt;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      cycles(1);
      if (rd_cnt != bn) ok = 1'b1;
    end
    chk("wait_req_seen", 32'(ok), 1);
    cycles(5);
    lat      = 20;
    base_ack = ack_cnt;
    base_rd  = rd_cnt;
    base_ix  = obs_addr_q.size();
    exp_q.push_back(16'hD100);
    pulse_restart(26'h3100, 26'h31FF);
    chk("wait_restart_underrun", 32'(underrun), 0);
    chk("wait_restart_level", 32'(level), 0);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      cycles(1);
      if (ack_cnt != base_ack) ok = 1'b1;
    end
    chk("wait_ack_pulse", 32'(ok), 1);
    cycles(2);
    chk("wait_stale_dropped", 32'(level), 0);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      cycles(1);
      if (rd_cnt != base_rd) ok = 1'b1;
    end
    chk("wait_next_req", 32'(ok), 1);
    chk_addr("wait_next_addr", base_ix, 26'h3100);
    cycles(30);
    sample_req();
    es = exp_q.pop_front();
    chk("wait_first_sample", 32'(sample_out), 32'(es));

    // ---- pause with five samples buffered ----
    lat     = 3;
    base_rd = rd_cnt;
    exp_q.push_back(16'hE000);
    pulse_restart(26'h4000, 26'h4FFF);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      cycles(1);
      if (rd_cnt - base_rd >= 5) ok = 1'b1;
    end
    play = 1'b0;
    chk("pause_fill_seen", 32'(ok), 1);
    cycles(30);
    chk("pause_level5", 32'(level), 5);
    chk("pause_reads5", 32'(rd_cnt - base_rd), 5);
    play  = 1'b1;
    pause = 1'b1;
    u0    = int'(underrun);
    for (int k = 0; k < 3; k++) begin
      sample_req();
      chk($sformatf("pause_sample%0d", k), 32'(sample_out), 0);
      chk($sformatf("pause_level%0d", k), 32'(level), 5);
    end
    cycles(20);
    chk("pause_no_reads", 32'(rd_cnt - base_rd), 5);
    chk("pause_underrun", 32'(underrun), 32'(u0));
    pause = 1'b0;
    sample_req();
    es = exp_q.pop_front();
    chk("pause_resume_sample", 32'(sample_out), 32'(es));

`ifdef LOOP_PLAYBACK_EN
    // ---- looping playback over a two-word range ----
    base_ix = obs_addr_q.size();
    pulse_restart(26'h0010, 26'h0011);
    cycles(150);
    for (int i = 0; i < 6; i++)
      chk_addr($sformatf("loop_addr%0d", i), base_ix + i, (i % 2 == 0) ? 26'h0010 : 26'h0011);
    chk("loop_done", 32'(done), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
